alu_mul_sequencer: RTL

//  Issue/sequencing controller for the execute-stage ALU. Accepts one op per request
//  (3-bit ALU control code), completes and/or/add/sub in one cycle, and runs mul as an

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_sequencer_if.sv | 26 ++
 rtl/alu_mul_sequencer_mul_iter_core.sv | 55 +++++
 rtl/alu_mul_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU op codes and sequencer state encoding shared by the execute-stage ALU,
// ALU_Control and the multiply sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/result bundle between the issue stage and alu_mul_sequencer.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;
  logic             busy_o;
  logic             stall_o;
  logic             illegal_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i,
    input  result_o, valid_o, busy_o, stall_o, illegal_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i,
    output result_o, valid_o, busy_o, stall_o, illegal_o
  );

endinterface

// File: rtl/alu_mul_sequencer_mul_iter_core.sv
// Shift-add multiply datapath: operand shift registers, accumulator, iteration counter.
// MUL_EARLY_EXIT_EN adds a "remaining multiplier is zero" flag for early termination.
module mul_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             last_o,
  output logic             b_zero_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // Low WIDTH bits of the product are sign-agnostic, so the datapath is unsigned.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (init_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      if (b_q[0]) begin
        acc_q <= acc_q + a_q;
      end
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
  assign b_zero_o = (b_q == '0);
`else
  assign b_zero_o = 1'b0;
`endif

endmodule

// File: rtl/alu_mul_sequencer.sv
// Execute-stage ALU issue controller: single-cycle and/or/add/sub, iterative mul with
// pipeline stall. Optional MUL_EARLY_EXIT_EN ends the multiply once the multiplier is exhausted.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  alu_mul_sequencer_if.slave bus
);

  alu_state_e       state_q;
  alu_state_e       state_d;
  logic             is_mul;
  logic             mul_init;
  logic             mul_step;
  logic             load_single;
  logic             load_mul;
  logic [WIDTH-1:0] mul_acc;
  logic             mul_last;
  logic             mul_b_zero;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             illegal_q;

  function automatic logic [WIDTH-1:0] alu_single(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      default: return '0;
    endcase
  endfunction

  assign is_mul = (bus.ALUCtrl_i == ALU_MUL);

  mul_iter_core #(.WIDTH(WIDTH)) u_mul_iter_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .init_i   (mul_init),
    .step_i   (mul_step),
    .a_i      (bus.data1_i),
    .b_i      (bus.data2_i),
    .acc_o    (mul_acc),
    .last_o   (mul_last),
    .b_zero_o (mul_b_zero)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // b_zero is tied low in the fixed-latency build, leaving the counter as the only exit.
  always_comb begin
    state_d     = state_q;
    mul_init    = 1'b0;
    mul_step    = 1'b0;
    load_single = 1'b0;
    load_mul    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (is_mul) begin
            mul_init = 1'b1;
            state_d  = RUN;
          end else begin
            load_single = 1'b1;
          end
        end
      end
      RUN: begin
        if (mul_b_zero) begin
          state_d = DONE;
        end else begin
          mul_step = 1'b1;
          if (mul_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        load_mul = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= load_single | load_mul;
      illegal_q <= load_single & ~op_is_legal(bus.ALUCtrl_i);
      if (load_single) begin
        result_q <= alu_single(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);
      end else if (load_mul) begin
        result_q <= mul_acc;
      end
    end
  end

  // Stall is raised combinationally in the accept cycle so upstream operands hold.
  assign bus.result_o  = result_q;
  assign bus.valid_o   = valid_q;
  assign bus.illegal_o = illegal_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.stall_o   = (state_q != IDLE) | ((state_q == IDLE) & bus.start_i & is_mul);

endmodule
